// File: rtl/rd_arbiter_pkg.sv
// Shared constants for the two-requester read arbiter: request types,
// FSM state encodings, burst owner codes and the line-compare helper.
package rd_arbiter_pkg;

  localparam logic [2:0] RD_TYPE_WORD = 3'b010;
  localparam logic [2:0] RD_TYPE_LINE = 3'b100;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic OWNER_IC = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  // True when a and b fall in the same cache line; mask keeps the line-index bits.
  function automatic logic same_line(input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] mask);
    return ((a ^ b) & mask) == 32'd0;
  endfunction

endpackage

// File: rtl/rd_arbiter.sv
// Arbitrates icache refills and data-side reads onto the single AXI read
// bridge, one burst at a time, with write-buffer hazard hold and anti-starvation.
//
// state   | meaning
// IDLE    | no burst in flight; same-cycle grant to ic or dm
// REQ     | bus_rd_req high with latched type/addr, waiting for bus_rd_rdy
// DATA    | forwarding return beats to owner until the last beat
module rd_arbiter
  import rd_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int LINE_OFS     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ic_rd_req,
  input  logic [2:0]  ic_rd_type,
  input  logic [31:0] ic_rd_addr,
  output logic        ic_rd_rdy,
  output logic        ic_ret_valid,
  input  logic        dm_rd_req,
  input  logic [2:0]  dm_rd_type,
  input  logic [31:0] dm_rd_addr,
  output logic        dm_rd_rdy,
  output logic        dm_ret_valid,
  output logic        ret_last,
  output logic [31:0] ret_data,
  input  logic        wb_busy,
  input  logic [31:0] wb_addr,
  output logic        bus_rd_req,
  output logic [2:0]  bus_rd_type,
  output logic [31:0] bus_rd_addr,
  input  logic        bus_rd_rdy,
  input  logic        bus_ret_valid,
  input  logic        bus_ret_last,
  input  logic [31:0] bus_ret_data
);

  localparam logic [3:0]  LIMIT     = 4'(STARVE_LIMIT);
  localparam logic [31:0] LINE_MASK = ~((32'd1 << LINE_OFS) - 32'd1);

  logic [1:0]  state_q,  state_d;
  logic        owner_q,  owner_d;
  logic [3:0]  streak_q, streak_d;
  logic [2:0]  type_q,   type_d;
  logic [31:0] addr_q,   addr_d;

  logic dm_haz, dm_ok, ic_ok, grant_ic, grant_dm, in_data;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    streak_d  = streak_q;
    type_d    = type_q;
    addr_d    = addr_q;
    ic_rd_rdy = 1'b0;
    dm_rd_rdy = 1'b0;

    // A dm read that hits a line still sitting in the write buffer must wait.
    dm_haz   = wb_busy && same_line(wb_addr, dm_rd_addr, LINE_MASK);
    dm_ok    = dm_rd_req && !dm_haz;
    ic_ok    = ic_rd_req;
    grant_ic = ic_ok && ((streak_q == LIMIT) || !dm_ok);
    grant_dm = !grant_ic && dm_ok;

    case (state_q)
      ST_IDLE: begin
        if (grant_ic) begin
          ic_rd_rdy = 1'b1;
          type_d    = ic_rd_type;
          addr_d    = ic_rd_addr;
          owner_d   = OWNER_IC;
          streak_d  = 4'd0;
          state_d   = ST_REQ;
        end else if (grant_dm) begin
          dm_rd_rdy = 1'b1;
          type_d    = dm_rd_type;
          addr_d    = dm_rd_addr;
          owner_d   = OWNER_DM;
          state_d   = ST_REQ;
          if (!ic_rd_req)
            streak_d = 4'd0;
          else if (streak_q != LIMIT)
            streak_d = streak_q + 4'd1;
        end
      end
      ST_REQ: begin
        if (bus_rd_rdy)
          state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bus_ret_valid && bus_ret_last)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWNER_IC;
      streak_q <= 4'd0;
      type_q   <= 3'd0;
      addr_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      type_q   <= type_d;
      addr_q   <= addr_d;
    end
  end

  assign in_data      = (state_q == ST_DATA);
  assign bus_rd_req   = (state_q == ST_REQ);
  assign bus_rd_type  = type_q;
  assign bus_rd_addr  = addr_q;
  assign ic_ret_valid = in_data && bus_ret_valid && (owner_q == OWNER_IC);
  assign dm_ret_valid = in_data && bus_ret_valid && (owner_q == OWNER_DM);
  assign ret_last     = in_data && bus_ret_valid && bus_ret_last;
  assign ret_data     = bus_ret_data;

endmodule

// File: doc/rd_arbiter.md
Name: rd_arbiter

Overview:
- Two-requester read arbiter in front of the single AXI read bridge.
- Requesters are the icache refill port and the data-side read port; the data side is already muxed between dcache and uncache by the MEM-stage cache select.
- Grants one read burst at a time, forwards the return beats to the owner, and holds data reads that hit a line still in the write buffer.
- Includes an anti-starvation counter so a stream of data reads cannot lock out instruction fetch.

Parameters:
STARVE_LIMIT, 4, consecutive dm grants made while ic waits before ic is forced to win (1..15)
LINE_OFS, 4, byte-offset bits ignored when comparing addresses for the write-buffer hazard (16-byte line)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ic_rd_req  in  1  icache read request
ic_rd_type  in  3  3'b100 line, 3'b010 word
ic_rd_addr  in  32  icache physical address
ic_rd_rdy  out  1  icache request accepted this cycle
ic_ret_valid  out  1  return beat valid for icache
dm_rd_req  in  1  data-side read request (dcache or uncache)
dm_rd_type  in  3  as ic_rd_type
dm_rd_addr  in  32  data-side physical address
dm_rd_rdy  out  1  data-side request accepted this cycle
dm_ret_valid  out  1  return beat valid for data side
ret_last  out  1  last beat of current burst (shared)
ret_data  out  32  return beat data (shared)
wb_busy  in  1  write buffer holds an unretired write
wb_addr  in  32  address of that write
bus_rd_req  out  1  read request to AXI bridge
bus_rd_type  out  3  registered type of granted request
bus_rd_addr  out  32  registered address of granted request
bus_rd_rdy  in  1  bridge accepted request
bus_ret_valid  in  1  bridge return beat valid
bus_ret_last  in  1  bridge last beat
bus_ret_data  in  32  bridge return data

Behaviour:
- Clock and reset: clk; rst synchronous, active-high.
- Reset state and outputs: state IDLE, owner=0, streak=0. Reset values: bus_rd_req 0, bus_rd_type 0, bus_rd_addr 0, all *_rdy 0, all *_ret_valid 0, ret_last 0. ret_data is don't-care but driven from bus_ret_data.
- States:
  - IDLE: no burst in flight.
  - REQ: bus_rd_req=1, waiting for bus_rd_rdy.
  - DATA: forwarding return beats.
- Hazard: dm_haz = wb_busy && (wb_addr[31:LINE_OFS] == dm_rd_addr[31:LINE_OFS]).
- Grant in IDLE, combinational, same cycle:
  - dm_ok = dm_rd_req && !dm_haz; ic_ok = ic_rd_req.
  - If ic_ok && (streak == STARVE_LIMIT || !dm_ok): grant ic.
  - Else if dm_ok: grant dm.
  - Else: no grant.
- Accept:
  - Granted requester sees its *_rd_rdy=1 in that IDLE cycle. *_rd_rdy is 0 in every other state.
  - On accept: latch type/addr into bus_rd_type/bus_rd_addr, set owner, go REQ.
  - bus_rd_req rises the cycle after accept: one-cycle grant latency.
- REQ:
  - bus_rd_req held high with stable type/addr until bus_rd_rdy.
  - Then go DATA; bus_rd_req=0 from the next cycle.
- DATA:
  - owner's ret_valid = bus_ret_valid; other ret_valid = 0.
  - ret_last = bus_ret_valid & bus_ret_last; ret_data = bus_ret_data. Zero added latency, combinational pass-through.
  - The block does not count beats. bus_ret_valid && bus_ret_last returns to IDLE next cycle, so the earliest next accept is the cycle after the last beat.
- Returns outside DATA: bus_ret_valid is ignored; both ret_valid stay 0.
- Streak counter, updated on accept:
  - dm grant with ic_rd_req=1: streak = min(streak+1, STARVE_LIMIT).
  - dm grant with ic_rd_req=0: streak = 0.
  - ic grant: streak = 0.
- Hazard vs ic: a hazard-blocked dm does not block ic. If only dm is requesting and dm_haz=1, stay IDLE until wb_busy drops or the address changes.
- Requests while busy: requesters must hold req/type/addr until *_rd_rdy; the arbiter never drops a pending request.
- Reset mid-burst: next cycle is IDLE with outputs at reset values. Remaining bridge beats are ignored.

Decomposition:
- Shared package/include holds RD_TYPE_WORD=3'b010, RD_TYPE_LINE=3'b100, state encodings IDLE/REQ/DATA and OWNER_IC/OWNER_DM.
- Single flat module. The hazard comparator and priority select are small enough not to warrant sub-modules.

Test Plan:
- ic line read 0x1FC0_0000 alone → ic_rd_rdy at T, bus_rd_req T+1 with type 3'b100, bus_rd_rdy T+2; 4 beats forwarded on ic_ret_valid, ret_last on beat 4; state back to IDLE.
- ic and dm requesting together, dm addr 0x0000_1000 → dm granted first; ic granted immediately after dm burst ends; streak 0 after ic grant.
- dm continuously requesting, ic held high, STARVE_LIMIT=4 → grants dm,dm,dm,dm,ic.
- wb_busy=1, wb_addr 0x0000_2008, dm_rd_addr 0x0000_200C, ic idle → no grant. Drop wb_busy → dm_rd_rdy the same cycle. With ic also requesting → ic granted while dm blocked.
- Stray bus_ret_valid=1 in IDLE and REQ → ic_ret_valid=dm_ret_valid=0, state unchanged.
- rst asserted in DATA after beat 2 → outputs at reset values next cycle; beats 3–4 not forwarded; new ic request is accepted normally afterward.
